h14tx_island_terc4: RTL and testbench
=====================================

Name: h14tx_island_terc4

Overview:
- Multi-lane data-island symbol generator for the HDMI 1.4 TX path.
- Frames one data island as leading guard band, TERC4-encoded payload, then trailing guard band.
- Emits one registered 10-bit symbol per lane per pixel clock.
- Sits between the packet assembler (upstream, valid/ready) and the lane serialisers.

Parameters:
- NUM_LANES, 3, number of TMDS lanes; lane 0 is the sync lane; must be >= 1.
- GUARD_LEN, 2, guard band length in cycles, before and after payload; must be >= 1.
- MAX_DATA, 32, maximum payload cycles per island before forced termination; must be >= 1.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous reset, active-high.
- start_i  in  1  pulse; starts an island, honoured only in IDLE.
- hsync_i  in  1  current HSYNC.
- vsync_i  in  1  current VSYNC.
- data_valid_i  in  1  payload nibble set valid.
- data_ready_o  out  1  payload accepted when valid && ready.
- data_i  in  NUM_LANES*4  payload nibbles; lane n = bits [4n+3:4n].
- data_last_i  in  1  marks the final payload beat.
- symbol_o  out  NUM_LANES*10  encoded symbols; lane n = bits [10n+9:10n].
- symbol_valid_o  out  1  symbol_o carries island content.
- guard_o  out  1  symbol_o is a guard-band symbol.
- busy_o  out  1  FSM not in IDLE.
- underrun_o  out  1  one-cycle pulse: DATA cycle with no valid payload.
- overrun_o  out  1  one-cycle pulse: MAX_DATA reached without last.

Behaviour:
- Reset values: all outputs 0, symbol_o all zeros, FSM in IDLE, counters 0.
- States:
  - IDLE: start_i -> LEAD.
  - LEAD: held for GUARD_LEN cycles -> DATA.
  - DATA: -> TRAIL on an accepted beat with data_last_i, or when the payload count reaches MAX_DATA.
  - TRAIL: held for GUARD_LEN cycles -> IDLE.
- start_i outside IDLE is ignored; it is not queued.
- data_ready_o is combinational and equals (state == DATA). It is never asserted in any other state.
- Latency: symbol_o, symbol_valid_o and guard_o are registered. The output reflects the state and inputs of the previous cycle, i.e. exactly 1 cycle.
- TERC4 mapping is the standard HDMI 1.4 16-entry table, implemented as a combinational function per lane.
- Guard symbols (LEAD/TRAIL):
  - Lane 0 = TERC4({1,1,vsync_i,hsync_i}).
  - Lanes >= 1 = 10'b0100110011.
  - symbol_valid_o=1, guard_o=1.
- DATA with a beat accepted: lane n = TERC4(data_i lane n); symbol_valid_o=1, guard_o=0.
- DATA without data_valid_i (underrun):
  - Lane 0 = TERC4({0,0,vsync_i,hsync_i}).
  - Lanes >= 1 = TERC4(4'b0000).
  - underrun_o pulses with the symbol.
  - The payload counter still increments.
- Payload counter:
  - $clog2(MAX_DATA+1) bits; counts DATA cycles; cleared on entry to DATA.
  - When it reaches MAX_DATA without an accepted last beat, FSM -> TRAIL and overrun_o pulses.
  - A beat with last on cycle MAX_DATA is a normal termination; no overrun.
- Guard counter: $clog2(GUARD_LEN+1) bits; cleared on each state entry; no wrap.
- IDLE outputs: symbol_valid_o=0, guard_o=0, symbol_o=0. Downstream emits control symbols in that case.
- Reset mid-island: immediate return to IDLE with outputs cleared; no trailing guard is produced.

Optional Feature:
- H14TX_TERC4_SYNC_INSERT_EN
  - Defined: during DATA, lane 0 nibble bits [1:0] are overwritten with {vsync_i,hsync_i} before encoding. Upstream lane-0 bits [3:2] are kept.
  - Undefined: data_i passes to the encoder unmodified.
  - All other behaviour is identical in both builds.

Test Plan:
- Reset, then idle for 5 cycles -> all outputs 0, busy_o=0, data_ready_o=0.
- start_i with hsync=1, vsync=0, GUARD_LEN=2 -> cycles 1-2 after start: lane0=1001110001, lanes1/2=0100110011, guard_o=1, symbol_valid_o=1.
- Then 4 beats: lane0=0000, lane1=0001, lane2=1111 each beat, last on beat 4 ->
  - 4 cycles of 1010011100/1001100011/1011000011.
  - Then 2 trail guard cycles.
  - Then IDLE with busy_o=0.
- Drop data_valid_i for 1 DATA cycle -> underrun_o single-cycle pulse; lanes1/2=1010011100; island continues.
- MAX_DATA=8, never assert last -> overrun_o pulses after 8 DATA cycles; TRAIL follows; a second start_i during DATA has no effect.
- With H14TX_TERC4_SYNC_INSERT_EN, data lane0=0000, hsync=1, vsync=1 -> lane0 symbol = TERC4(0011) = 1011100010. Without the macro -> 1010011100.
- Assert rst during DATA -> next cycle all outputs 0 and FSM in IDLE.

Source files
------------

// File: rtl/h14tx_island_terc4.sv
// HDMI 1.4 data-island symbol generator: lead guard, TERC4 payload, trail guard.
// Optional build macro H14TX_TERC4_SYNC_INSERT_EN inserts {vsync,hsync} into lane-0 payload.
module h14tx_island_terc4 #(
  parameter int NUM_LANES = 3,
  parameter int GUARD_LEN = 2,
  parameter int MAX_DATA  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     hsync_i,
  input  logic                     vsync_i,
  input  logic                     data_valid_i,
  output logic                     data_ready_o,
  input  logic [NUM_LANES*4-1:0]   data_i,
  input  logic                     data_last_i,
  output logic [NUM_LANES*10-1:0]  symbol_o,
  output logic                     symbol_valid_o,
  output logic                     guard_o,
  output logic                     busy_o,
  output logic                     underrun_o,
  output logic                     overrun_o
);

  localparam int PW = $clog2(MAX_DATA + 1);
  localparam int GW = $clog2(GUARD_LEN + 1);
  localparam logic [9:0] GUARD_SYM = 10'b0100110011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEAD  = 2'd1,
    S_DATA  = 2'd2,
    S_TRAIL = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [NUM_LANES*10-1:0] symbol_q, symbol_d;
  logic valid_q, valid_d;
  logic guard_q, guard_d;
  logic under_q, under_d;
  logic over_q, over_d;

  logic [GW-1:0] gcnt_inc;
  logic [PW-1:0] pcnt_inc;
  logic          guard_done;
  logic          pcnt_max;
  logic          accept;
  logic          last_beat;
  logic [3:0]    lane0_nib;

  function automatic logic [9:0] terc4(input logic [3:0] d);
    logic [9:0] s;
    case (d)
      4'h0: s = 10'b1010011100;
      4'h1: s = 10'b1001100011;
      4'h2: s = 10'b1011100100;
      4'h3: s = 10'b1011100010;
      4'h4: s = 10'b0101110001;
      4'h5: s = 10'b0100011110;
      4'h6: s = 10'b0110001110;
      4'h7: s = 10'b0100111100;
      4'h8: s = 10'b1011001100;
      4'h9: s = 10'b0100111001;
      4'hA: s = 10'b0110011100;
      4'hB: s = 10'b1011000110;
      4'hC: s = 10'b1010001110;
      4'hD: s = 10'b1001110001;
      4'hE: s = 10'b0101100011;
      default: s = 10'b1011000011;
    endcase
    return s;
  endfunction

`ifdef H14TX_TERC4_SYNC_INSERT_EN
  assign lane0_nib = {data_i[3:2], vsync_i, hsync_i};
`else
  assign lane0_nib = data_i[3:0];
`endif

  assign data_ready_o = (state_q == S_DATA);
  assign busy_o       = (state_q != S_IDLE);
  assign accept       = data_valid_i && data_ready_o;
  assign last_beat    = accept && data_last_i;
  assign gcnt_inc     = gcnt_q + GW'(1);
  assign pcnt_inc     = pcnt_q + PW'(1);
  assign guard_done   = (gcnt_inc == GW'(GUARD_LEN));
  assign pcnt_max     = (pcnt_inc == PW'(MAX_DATA));

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gcnt_q  <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
      pcnt_q  <= pcnt_d;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    pcnt_d  = pcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LEAD;
          gcnt_d  = '0;
        end
      end
      S_LEAD: begin
        gcnt_d = gcnt_inc;
        if (guard_done) begin
          state_d = S_DATA;
          gcnt_d  = '0;
          pcnt_d  = '0;
        end
      end
      S_DATA: begin
        pcnt_d = pcnt_inc;
        if (last_beat || pcnt_max) begin
          state_d = S_TRAIL;
          gcnt_d  = '0;
        end
      end
      S_TRAIL: begin
        gcnt_d = gcnt_inc;
        if (guard_done) begin
          state_d = S_IDLE;
          gcnt_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Symbol and status selection for the next output cycle
  always_comb begin
    symbol_d = '0;
    valid_d  = 1'b0;
    guard_d  = 1'b0;
    under_d  = 1'b0;
    over_d   = 1'b0;
    unique case (state_q)
      S_LEAD, S_TRAIL: begin
        valid_d       = 1'b1;
        guard_d       = 1'b1;
        symbol_d[9:0] = terc4({2'b11, vsync_i, hsync_i});
        for (int n = 1; n < NUM_LANES; n++)
          symbol_d[10*n +: 10] = GUARD_SYM;
      end
      S_DATA: begin
        valid_d = 1'b1;
        over_d  = pcnt_max && !last_beat;
        if (data_valid_i) begin
          symbol_d[9:0] = terc4(lane0_nib);
          for (int n = 1; n < NUM_LANES; n++)
            symbol_d[10*n +: 10] = terc4(data_i[4*n +: 4]);
        end else begin
          under_d       = 1'b1;
          symbol_d[9:0] = terc4({2'b00, vsync_i, hsync_i});
          for (int n = 1; n < NUM_LANES; n++)
            symbol_d[10*n +: 10] = terc4(4'b0000);
        end
      end
      default: ;
    endcase
  end

  // Output register: one cycle of latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      symbol_q <= '0;
      valid_q  <= 1'b0;
      guard_q  <= 1'b0;
      under_q  <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      symbol_q <= symbol_d;
      valid_q  <= valid_d;
      guard_q  <= guard_d;
      under_q  <= under_d;
      over_q   <= over_d;
    end
  end

  assign symbol_o       = symbol_q;
  assign symbol_valid_o = valid_q;
  assign guard_o        = guard_q;
  assign underrun_o     = under_q;
  assign overrun_o      = over_q;

endmodule

// File: tb/tb_h14tx_island_terc4.sv
// Self-checking bench for h14tx_island_terc4.
// Behavioural island model driven alongside randomized and directed stimulus.
module tb_h14tx_island_terc4;

  localparam int NL = 3;
  localparam int G  = 2;
  localparam int MX = 8;
  localparam int VW = NL*10 + 6;

  localparam logic [9:0] TERC [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0;
  logic hsync_i = 1'b0;
  logic vsync_i = 1'b0;
  logic data_valid_i = 1'b0;
  logic data_ready_o;
  logic [NL*4-1:0] data_i = '0;
  logic data_last_i = 1'b0;
  logic [NL*10-1:0] symbol_o;
  logic symbol_valid_o, guard_o, busy_o, underrun_o, overrun_o;

  int checks = 0;
  int failures = 0;

  // model: 0 idle, 1 leading guard, 2 payload, 3 trailing guard
  int mode = 0;
  int cnt = 0;
  logic [VW-1:0] exp_vec = '0;

  h14tx_island_terc4 #(.NUM_LANES(NL), .GUARD_LEN(G), .MAX_DATA(MX)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .hsync_i(hsync_i),
    .vsync_i(vsync_i), .data_valid_i(data_valid_i),
    .data_ready_o(data_ready_o), .data_i(data_i),
    .data_last_i(data_last_i), .symbol_o(symbol_o),
    .symbol_valid_o(symbol_valid_o), .guard_o(guard_o),
    .busy_o(busy_o), .underrun_o(underrun_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] obs();
    return {symbol_o, symbol_valid_o, guard_o, underrun_o, overrun_o,
            busy_o, data_ready_o};
  endfunction

  // Apply one cycle of inputs, advance the model, land #1 after the edge.
  task automatic tick(input bit st, input bit hs, input bit vs,
                      input bit dv, input logic [NL*4-1:0] d,
                      input bit lst);
    logic [NL*10-1:0] s;
    logic [3:0] n0;
    bit v, g, u, o;
    start_i = st; hsync_i = hs; vsync_i = vs;
    data_valid_i = dv; data_i = d; data_last_i = lst;
    s = '0; v = 0; g = 0; u = 0; o = 0;
    if (mode == 0) begin
      if (st) begin mode = 1; cnt = 0; end
    end else if (mode == 1 || mode == 3) begin
      v = 1; g = 1;
      s[9:0] = TERC[{2'b11, vs, hs}];
      for (int n = 1; n < NL; n++) s[10*n +: 10] = 10'b0100110011;
      cnt++;
      if (cnt == G) begin mode = (mode == 1) ? 2 : 0; cnt = 0; end
    end else begin
      v = 1;
      cnt++;
      if (dv) begin
`ifdef H14TX_TERC4_SYNC_INSERT_EN
        n0 = {d[3:2], vs, hs};
`else
        n0 = d[3:0];
`endif
        s[9:0] = TERC[n0];
        for (int n = 1; n < NL; n++) s[10*n +: 10] = TERC[d[4*n +: 4]];
      end else begin
        u = 1;
        s[9:0] = TERC[{2'b00, vs, hs}];
        for (int n = 1; n < NL; n++) s[10*n +: 10] = TERC[0];
      end
      if (dv && lst) begin
        mode = 3; cnt = 0;
      end else if (cnt == MX) begin
        o = 1; mode = 3; cnt = 0;
      end
    end
    @(posedge clk);
    #1;
    exp_vec = {s, v, g, u, o, mode != 0, mode == 2};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mode = 0; cnt = 0; exp_vec = '0;
    checks++;
    if (obs() !== exp_vec) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=%h", obs(), exp_vec);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 0, '0, 0);
      checks++;
      if (obs() !== exp_vec) begin
        failures++;
        $display("FAIL reset_idle[%0d] got=%h exp=%h", i, obs(), exp_vec);
      end
    end
  endtask

  task automatic test_guard_and_payload();
    logic [9:0] l0;
    tick(1, 1, 0, 0, '0, 0);
    checks++;
    if (obs() !== exp_vec) begin
      failures++;
      $display("FAIL gp_start got=%h exp=%h", obs(), exp_vec);
    end
    for (int i = 0; i < G; i++) begin
      tick(0, 1, 0, 0, '0, 0);
      checks++;
      if (obs() !== exp_vec || symbol_o !== {10'b0100110011, 10'b0100110011,
          10'b1001110001} || guard_o !== 1'b1) begin
        failures++;
        $display("FAIL gp_lead[%0d] got=%h exp=%h", i, obs(), exp_vec);
      end
    end
`ifdef H14TX_TERC4_SYNC_INSERT_EN
    l0 = 10'b1001100011;
`else
    l0 = 10'b1010011100;
`endif
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, 0, 1, 12'hF10, i == 3);
      checks++;
      if (obs() !== exp_vec || symbol_o !== {10'b1011000011, 10'b1001100011,
          l0} || guard_o !== 1'b0 || symbol_valid_o !== 1'b1) begin
        failures++;
        $display("FAIL gp_data[%0d] got=%h exp=%h", i, obs(), exp_vec);
      end
    end
    for (int i = 0; i < G + 1; i++) begin
      tick(0, 1, 0, 0, '0, 0);
      checks++;
      if (obs() !== exp_vec) begin
        failures++;
        $display("FAIL gp_trail[%0d] got=%h exp=%h", i, obs(), exp_vec);
      end
    end
    checks++;
    if (busy_o !== 1'b0 || data_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL gp_end_idle busy=%b ready=%b exp=0", busy_o, data_ready_o);
    end
  endtask

  task automatic test_underrun();
    tick(1, 0, 0, 0, '0, 0);
    for (int i = 0; i < G; i++) tick(0, 0, 0, 0, '0, 0);
    tick(0, 0, 0, 1, 12'h5A3, 0);
    tick(0, 1, 0, 0, 12'hFFF, 0);
    checks++;
    if (obs() !== exp_vec || underrun_o !== 1'b1 ||
        symbol_o[29:10] !== {10'b1010011100, 10'b1010011100}) begin
      failures++;
      $display("FAIL underrun_pulse got=%h exp=%h", obs(), exp_vec);
    end
    tick(0, 0, 0, 1, 12'h123, 0);
    checks++;
    if (obs() !== exp_vec || underrun_o !== 1'b0 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL underrun_clear got=%h exp=%h", obs(), exp_vec);
    end
    tick(0, 0, 0, 1, 12'h456, 1);
    for (int i = 0; i < G + 1; i++) begin
      tick(0, 0, 0, 0, '0, 0);
      checks++;
      if (obs() !== exp_vec) begin
        failures++;
        $display("FAIL underrun_tail[%0d] got=%h exp=%h", i, obs(), exp_vec);
      end
    end
  endtask

  task automatic test_overrun();
    tick(1, 0, 1, 0, '0, 0);
    for (int i = 0; i < G; i++) tick(0, 0, 1, 0, '0, 0);
    for (int i = 0; i < MX; i++) begin
      tick(i == 2, 0, 1, 1, 12'(i * 37), 0);
      checks++;
      if (obs() !== exp_vec || overrun_o !== (i == MX - 1)) begin
        failures++;
        $display("FAIL overrun_beat[%0d] got=%h exp=%h ovr=%b", i, obs(),
                 exp_vec, overrun_o);
      end
    end
    for (int i = 0; i < G + 3; i++) begin
      tick(0, 0, 1, 1, 12'h777, 0);
      checks++;
      if (obs() !== exp_vec) begin
        failures++;
        $display("FAIL overrun_tail[%0d] got=%h exp=%h", i, obs(), exp_vec);
      end
    end
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL overrun_no_restart busy=%b exp=0", busy_o);
    end
  endtask

  task automatic test_sync_insert();
    logic [9:0] l0;
`ifdef H14TX_TERC4_SYNC_INSERT_EN
    l0 = 10'b1011100010;
`else
    l0 = 10'b1010011100;
`endif
    tick(1, 1, 1, 0, '0, 0);
    for (int i = 0; i < G; i++) tick(0, 1, 1, 0, '0, 0);
    tick(0, 1, 1, 1, 12'h000, 1);
    checks++;
    if (obs() !== exp_vec || symbol_o[9:0] !== l0) begin
      failures++;
      $display("FAIL sync_insert lane0 got=%b exp=%b", symbol_o[9:0], l0);
    end
    for (int i = 0; i < G + 1; i++) tick(0, 0, 0, 0, '0, 0);
    checks++;
    if (obs() !== exp_vec) begin
      failures++;
      $display("FAIL sync_tail got=%h exp=%h", obs(), exp_vec);
    end
  endtask

  task automatic test_reset_mid();
    tick(1, 0, 0, 0, '0, 0);
    for (int i = 0; i < G + 2; i++) tick(0, 0, 0, 1, 12'hABC, 0);
    rst = 1'b1;
    #1;
    mode = 0; cnt = 0; exp_vec = '0;
    checks++;
    if (obs() !== exp_vec) begin
      failures++;
      $display("FAIL reset_mid got=%h exp=%h", obs(), exp_vec);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 1, 1, 12'hFFF, 0);
      checks++;
      if (obs() !== exp_vec) begin
        failures++;
        $display("FAIL reset_mid_idle[%0d] got=%h exp=%h", i, obs(), exp_vec);
      end
    end
  endtask

  task automatic test_random();
    bit st, dv, lst;
    for (int i = 0; i < 800; i++) begin
      st  = ($urandom_range(0, 9) == 0);
      dv  = ($urandom_range(0, 9) < 8);
      lst = dv && ($urandom_range(0, 5) == 0);
      tick(st, 1'($urandom), 1'($urandom), dv, 12'($urandom), lst);
      checks++;
      if (obs() !== exp_vec) begin
        failures++;
        $display("FAIL random[%0d] got=%h exp=%h", i, obs(), exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_guard_and_payload();
    test_underrun();
    test_overrun();
    test_sync_insert();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
